// File: rtl/ram_byte_master.sv
// ram_byte_master: turns one CPU byte/half/word request into sequential byte
// accesses on a byte-wide single-port RAM. Little-endian, unaligned allowed.
// Latency: 1 + N*RAM_LATENCY + stall cycles from accepting edge to done high.
// Backpressure: loads stall while i_ramBusy is high; after TIMEOUT stall
// cycles on one byte the request aborts with o_error. Stores ignore busy.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_req                     request strobe, sampled only in IDLE
//   i_write, i_size, i_addr,  request: 1=store; 00 byte, 01 half, 10 word,
//   i_wdata                   11 illegal; LSB byte address; store data
//   o_rdata                   load result, zero-extended
//   o_busy, o_done, o_error   status; done/error are one-cycle pulses
//   o_ramAddr, o_ramDataOut,  to RAM addrA / dataIn / writeEnable
//   o_ramWriteEnable
//   i_ramDataIn, i_ramBusy    from RAM outA / busyA
module ram_byte_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int RAM_LATENCY   = 1,
  parameter int TIMEOUT       = 64
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req,
  input  logic                     i_write,
  input  logic [1:0]               i_size,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [ADDRESS_WIDTH-1:0] o_ramAddr,
  output logic [7:0]               o_ramDataOut,
  output logic                     o_ramWriteEnable,
  input  logic [7:0]               i_ramDataIn,
  input  logic                     i_ramBusy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  // Counters hold "cycles already spent", so the limit is compared against
  // the value minus one: the current cycle is the last one when they match.
  localparam logic [3:0] LAT_LAST = 4'(RAM_LATENCY - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t                   r_state;
  logic                     r_write;
  logic [1:0]               r_last;    // N-1: index of the final byte
  logic [1:0]               r_idx;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_wdata;
  logic [3:0]               r_lat;
  logic [7:0]               r_stall;
  logic [31:0]              r_rdata;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic [ADDRESS_WIDTH-1:0] r_ram_addr;
  logic [7:0]               r_ram_dout;
  logic                     r_ram_we;

  logic                     w_lat_met;
  logic                     w_byte_ok;
  logic                     w_timeout;
  logic [1:0]               w_next_idx;
  logic [ADDRESS_WIDTH-1:0] w_next_addr;
  logic [7:0]               w_next_wbyte;
  logic [1:0]               w_req_last;

  assign w_lat_met    = (r_lat == LAT_LAST);
  // Stores complete on latency alone; loads additionally need the RAM idle.
  assign w_byte_ok    = r_write | ~i_ramBusy;
  assign w_timeout    = (r_stall == TO_LAST);
  assign w_next_idx   = r_idx + 2'd1;
  // Offset from the latched base so the address wraps modulo 2^ADDRESS_WIDTH.
  assign w_next_addr  = r_addr + ADDRESS_WIDTH'(w_next_idx);
  assign w_next_wbyte = r_wdata[{w_next_idx, 3'b000} +: 8];

  always_comb begin
    w_req_last = 2'd0;
    case (i_size)
      2'b00:   w_req_last = 2'd0;
      2'b01:   w_req_last = 2'd1;
      2'b10:   w_req_last = 2'd3;
      default: w_req_last = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_last     <= 2'd0;
      r_idx      <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_lat      <= 4'd0;
      r_stall    <= 8'd0;
      r_rdata    <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_ram_addr <= '0;
      r_ram_dout <= 8'd0;
      r_ram_we   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_busy <= 1'b1;
            if (i_size == 2'b11) begin
              // Illegal size: report immediately, leave the RAM side alone.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state    <= ST_ACCESS;
              r_write    <= i_write;
              r_last     <= w_req_last;
              r_addr     <= i_addr;
              r_wdata    <= i_wdata;
              r_idx      <= 2'd0;
              r_lat      <= 4'd0;
              r_stall    <= 8'd0;
              r_rdata    <= 32'd0;
              r_ram_addr <= i_addr;
              if (i_write) begin
                r_ram_dout <= i_wdata[7:0];
                r_ram_we   <= 1'b1;
              end
            end
          end
        end

        ST_ACCESS: begin
          if (!w_lat_met) begin
            r_lat <= r_lat + 4'd1;
          end else if (w_byte_ok) begin
            if (!r_write) begin
              r_rdata[{r_idx, 3'b000} +: 8] <= i_ramDataIn;
            end
            if (r_idx == r_last) begin
              r_ram_we <= 1'b0;
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
            end else begin
              r_idx      <= w_next_idx;
              r_ram_addr <= w_next_addr;
              r_lat      <= 4'd0;
              r_stall    <= 8'd0;
              if (r_write) begin
                r_ram_dout <= w_next_wbyte;
              end
            end
          end else if (w_timeout) begin
            // Abort: uncaptured bytes stay zero from the clear at accept.
            r_ram_we <= 1'b0;
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_error  <= 1'b1;
          end else begin
            r_stall <= r_stall + 8'd1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_done   <= 1'b0;
          r_error  <= 1'b0;
          r_busy   <= 1'b0;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign o_rdata          = r_rdata;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_error          = r_error;
  assign o_ramAddr        = r_ram_addr;
  assign o_ramDataOut     = r_ram_dout;
  assign o_ramWriteEnable = r_ram_we;

endmodule

// File: tb/tb_ram_byte_master.sv
// Bench for ram_byte_master: table of requests with expected results pushed
// to a scoreboard at issue and popped when done pulses, plus hand sequences
// for reset behaviour. Byte-wide RAM model with controllable busy.
module tb_ram_byte_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic        ram_busy = 1'b0;
  logic        preload = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ram_byte_master #(
    .ADDRESS_WIDTH(32),
    .RAM_LATENCY(1),
    .TIMEOUT(4)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_req(req),
    .i_write(wr),
    .i_size(sz),
    .i_addr(addr),
    .i_wdata(wdata),
    .o_rdata(rdata),
    .o_busy(busy),
    .o_done(done),
    .o_error(err),
    .o_ramAddr(ram_addr),
    .o_ramDataOut(ram_dout),
    .o_ramWriteEnable(ram_we),
    .i_ramDataIn(ram_din),
    .i_ramBusy(ram_busy)
  );

  // RAM model: 256 bytes aliased over the address space, async read.
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mem [0:255];
  wr_t wlog[$];

  assign ram_din = mem[ram_addr[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'h11;
      mem[8'h11] <= 8'h22;
      mem[8'h12] <= 8'h33;
      mem[8'h13] <= 8'h44;
      mem[8'hFF] <= 8'hAA;
      mem[8'h00] <= 8'h01;
      mem[8'h01] <= 8'h02;
      mem[8'h02] <= 8'h03;
    end else if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_dout;
      wlog.push_back('{ram_addr[7:0], ram_dout});
    end
  end

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nbusy;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    bit          chk_addr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int vi);
    logic [31:0] trace[$];
    logic [31:0] addr_before;
    logic [31:0] ea;
    exp_t        e;
    bit          seen;
    int          start_w;
    int          nw;
    int          n;
    string       tag;
    tag = $sformatf("v%0d", vi);
    n = nbytes(v.sz);
    @(negedge clk);
    addr_before = ram_addr;
    start_w = wlog.size();
    req = 1'b1;
    wr = v.wr;
    sz = v.sz;
    addr = v.addr;
    wdata = v.wdata;
    ram_busy = (v.nbusy > 0);
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, cyc + 1});
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      // Scramble request inputs while busy; the DUT must ignore them.
      req = 1'b0;
      wr = ~v.wr;
      sz = 2'b10;
      addr = 32'hDEAD_0000;
      wdata = ~v.wdata;
      ram_busy = (k <= v.nbusy);
      if (done) begin
        seen = 1;
        e = sb.pop_front();
        chk({tag, "_rdata"}, rdata, e.rdata);
        chk({tag, "_error"}, {31'd0, err}, {31'd0, e.err});
        chk({tag, "_latency"}, 32'(cyc - e.issue + 1), 32'(e.lat));
        chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        chk({tag, "_we_in_done"}, {31'd0, ram_we}, 32'd0);
      end else if (busy) begin
        trace.push_back(ram_addr);
      end
    end
    ram_busy = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_done_timeout actual=no_done required=done", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (v.chk_addr) begin
      chk({tag, "_ncycles"}, 32'(trace.size()), 32'(n));
      for (int i = 0; i < trace.size() && i < n; i++) begin
        chk($sformatf("%s_addr%0d", tag, i), trace[i], v.addr + 32'(i));
      end
    end
    if (v.sz == 2'b11) chk({tag, "_addr_hold"}, ram_addr, addr_before);
    nw = wlog.size() - start_w;
    chk({tag, "_nwrites"}, 32'(nw), (v.wr && v.sz != 2'b11) ? 32'(n) : 32'd0);
    for (int i = 0; i < nw && i < n; i++) begin
      ea = v.addr + 32'(i);
      chk($sformatf("%s_wa%0d", tag, i), {24'd0, wlog[start_w + i].a}, {24'd0, ea[7:0]});
      chk($sformatf("%s_wd%0d", tag, i), {24'd0, wlog[start_w + i].d}, {24'd0, v.wdata[8*i +: 8]});
    end
  endtask

  initial begin
    vec_t vecs[13];
    vec_t again;
    int   nw0;
    bit   stray_done;

    vecs[0]  = '{0, 2'b10, 32'h0000_0010, 32'h0,         0,  32'h4433_2211, 0, 5, 1};
    vecs[1]  = '{0, 2'b00, 32'h0000_0012, 32'h0,         0,  32'h0000_0033, 0, 2, 1};
    vecs[2]  = '{0, 2'b01, 32'h0000_0011, 32'h0,         0,  32'h0000_3322, 0, 3, 1};
    vecs[3]  = '{0, 2'b00, 32'h0000_0013, 32'h0,         3,  32'h0000_0044, 0, 5, 0};
    vecs[4]  = '{0, 2'b10, 32'hFFFF_FFFF, 32'h0,         0,  32'h0302_01AA, 0, 5, 1};
    vecs[5]  = '{1, 2'b11, 32'h0000_0010, 32'hCAFE_F00D, 0,  32'h0302_01AA, 1, 1, 1};
    vecs[6]  = '{1, 2'b01, 32'h0000_0021, 32'h0000_BEEF, 0,  32'h0000_0000, 0, 3, 1};
    vecs[7]  = '{0, 2'b01, 32'h0000_0021, 32'h0,         0,  32'h0000_BEEF, 0, 3, 1};
    vecs[8]  = '{1, 2'b10, 32'h0000_0040, 32'h1234_5678, 2,  32'h0000_0000, 0, 5, 1};
    vecs[9]  = '{0, 2'b10, 32'h0000_0040, 32'h0,         0,  32'h1234_5678, 0, 5, 1};
    vecs[10] = '{0, 2'b10, 32'h0000_0010, 32'h0,         99, 32'h0000_0000, 1, 5, 0};
    vecs[11] = '{0, 2'b00, 32'h0000_0010, 32'h0,         3,  32'h0000_0011, 0, 5, 0};
    vecs[12] = '{0, 2'b01, 32'h0000_0011, 32'h0,         3,  32'h0000_3322, 0, 6, 0};

    // Reset is high from time zero; outputs must clear before any clock edge.
    #2;
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_done", {31'd0, done}, 32'd0);
    chk("rst_async_we", {31'd0, ram_we}, 32'd0);
    chk("rst_async_rdata", rdata, 32'd0);
    chk("rst_async_addr", ram_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_busy", {31'd0, busy}, 32'd0);
    chk("rst_rel_err", {31'd0, err}, 32'd0);
    chk("rst_rel_dout", {24'd0, ram_dout}, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Reset while the second byte of a word store is on the bus.
    @(negedge clk);
    nw0 = wlog.size();
    req = 1'b1; wr = 1'b1; sz = 2'b10; addr = 32'h0000_0080; wdata = 32'hA1B2_C3D4;
    @(negedge clk);
    req = 1'b0;
    chk("rs_b0_we", {31'd0, ram_we}, 32'd1);
    chk("rs_b0_addr", ram_addr, 32'h0000_0080);
    @(negedge clk);
    chk("rs_b1_we", {31'd0, ram_we}, 32'd1);
    chk("rs_b1_addr", ram_addr, 32'h0000_0081);
    chk("rs_b1_dout", {24'd0, ram_dout}, 32'h0000_00C3);
    #1 rst = 1'b1;
    #1;
    chk("rs_async_we", {31'd0, ram_we}, 32'd0);
    chk("rs_async_busy", {31'd0, busy}, 32'd0);
    chk("rs_async_addr", ram_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) stray_done = 1;
    end
    chk("rs_no_done", {31'd0, stray_done}, 32'd0);
    chk("rs_nwrites", 32'(wlog.size() - nw0), 32'd1);

    again = '{0, 2'b10, 32'h0000_0010, 32'h0, 0, 32'h4433_2211, 0, 5, 1};
    run_vec(again, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
